mult_share_arb: RTL and testbench

Round-robin arbiter that shares a single `mult_wrapper` 8x8 approximate multiplier among `NUM_REQ` requesters. It sits directly in front of the multiplier. It accepts one operand pair per cycle through per-requester valid/ready handshakes, drives the multiplier inputs, and tracks each issued operation through the fixed-latency multiplier pipeline with a requester tag. It returns each 16-bit product to the originating requester as a one-cycle response pulse.

---
 rtl/mult_share_arb_pkg.sv | 16 +
 rtl/mult_share_arb_if.sv | 27 ++
 rtl/mult_share_arb_tag_pipe.sv | 42 ++++
 rtl/mult_wrapper.sv | 27 ++
 rtl/mult_share_arb.sv | 118 +++++++++++
 tb/tb_mult_share_arb.sv | 303 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mult_share_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
//   MULT_W  : operand width of the shared multiplier
//   PROD_W  : product width of the shared multiplier
//   MAX_REQ : largest supported requester count (ids fit in ID_W bits)
//   mult_tag_t : one in-flight operation {valid, requester id}
package mult_pkg;
    localparam int MULT_W  = 8;
    localparam int PROD_W  = 16;
    localparam int MAX_REQ = 8;
    localparam int ID_W    = 3;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } mult_tag_t;
endpackage

// File: rtl/mult_share_arb_if.sv
// Requester-side bus of the multiplier-sharing arbiter.
//   req_valid/req_ready : per-requester handshake (ready is a one-hot grant)
//   req_a/req_b         : packed operands, slice i belongs to requester i
//   rsp_valid/rsp_y     : one-hot one-cycle product pulse and the product
// master = requester side, slave = arbiter side.
interface mult_share_arb_if #(
    parameter int NUM_REQ = 4
);
    import mult_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*MULT_W-1:0] req_a;
    logic [NUM_REQ*MULT_W-1:0] req_b;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [PROD_W-1:0]         rsp_y;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_y
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_y
    );
endinterface

// File: rtl/mult_share_arb_tag_pipe.sv
// MULT_LAT-deep shift register of {valid, id} tags that tracks operations
// through the fixed-latency multiplier. Only the valids are reset; ids are
// don't-care whenever their valid is low.
//   clk, rst_n : clock, async active-low reset
//   tag_i      : tag of the operation issued this cycle
//   tag_o      : tag of the operation whose product is on mult_y now
//   busy_o     : any stage holds a valid operation
module mult_tag_pipe
    import mult_pkg::*;
#(
    parameter int MULT_LAT = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  mult_tag_t tag_i,
    output mult_tag_t tag_o,
    output logic      busy_o
);
    logic [MULT_LAT-1:0] vld_q;
    logic [ID_W-1:0]     id_q [MULT_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= tag_i.valid;
            for (int k = 1; k < MULT_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        id_q[0] <= tag_i.id;
        for (int k = 1; k < MULT_LAT; k++) begin
            id_q[k] <= id_q[k-1];
        end
    end

    assign tag_o  = '{valid: vld_q[MULT_LAT-1], id: id_q[MULT_LAT-1]};
    assign busy_o = |vld_q;
endmodule

// File: rtl/mult_wrapper.sv
// Approximate 8x8 multiplier with registered inputs and registered output
// (two clock edges from inA/inB to Y). The three low product bits are
// replaced by a cheap OR of the operand low bits, so Y is within 7 of the
// exact product. No reset: the datapath is flushed by normal operation.
//   clk     : rising-edge clock
//   inA/inB : operands, captured at edge 1
//   Y       : approximate product, updated at edge 2
module mult_wrapper
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic [MULT_W-1:0] inA,
    input  logic [MULT_W-1:0] inB,
    output logic [PROD_W-1:0] Y
);
    logic [MULT_W-1:0] a_q;
    logic [MULT_W-1:0] b_q;
    logic [PROD_W-1:0] prod;

    assign prod = PROD_W'(a_q) * PROD_W'(b_q);

    always_ff @(posedge clk) begin
        a_q <= inA;
        b_q <= inB;
        Y   <= (prod & ~PROD_W'(7)) | PROD_W'(a_q[2:0] | b_q[2:0]);
    end
endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one mult_wrapper among NUM_REQ requesters.
// Grants one operand pair per cycle, steers it straight into the
// multiplier (which registers its own inputs) and returns each product to
// its requester MULT_LAT cycles later via a tag pipeline.
//   clk, rst_n      : clock, async active-low reset
//   req_if          : requester handshake, operands and responses
//   mult_a/mult_b   : operands to mult_wrapper (0 when nothing is granted)
//   mult_y          : product from mult_wrapper
//   busy            : any operation in flight
//   issue_cnt       : accepted handshakes since reset, wrapping
module mult_share_arb
    import mult_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MULT_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_share_arb_if.slave   req_if,
    output logic [MULT_W-1:0] mult_a,
    output logic [MULT_W-1:0] mult_b,
    input  logic [PROD_W-1:0] mult_y,
    output logic              busy,
    output logic [31:0]       issue_cnt
);
    localparam logic [ID_W:0]   NREQ    = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] NREQ_M1 = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [31:0]        issue_cnt_q, issue_cnt_d;
    logic [ID_W:0]      pos;
    logic               grant_vld;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] rsp_valid;
    mult_tag_t          tag_in, tag_out;

    // Walk offsets 0..NUM_REQ-1 from the pointer; the first valid requester
    // found wins. pos is the requester index sitting k places after rr_ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        pos       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!grant_vld && req_if.req_valid[j] && pos == (ID_W+1)'(j)) begin
                    grant_vld = 1'b1;
                    grant_id  = ID_W'(j);
                end
            end
        end
    end

    always_comb begin
        grant  = '0;
        mult_a = '0;
        mult_b = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_vld && grant_id == ID_W'(j)) begin
                grant[j] = 1'b1;
                mult_a   = req_if.req_a[j*MULT_W +: MULT_W];
                mult_b   = req_if.req_b[j*MULT_W +: MULT_W];
            end
        end
    end

    assign req_if.req_ready = grant;

    // A grant is always a handshake: it is only given to a valid requester.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        issue_cnt_d = issue_cnt_q;
        if (grant_vld) begin
            rr_ptr_d    = (grant_id == NREQ_M1) ? '0 : grant_id + 1'b1;
            issue_cnt_d = issue_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            issue_cnt_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign tag_in = '{valid: grant_vld, id: grant_id};

    mult_tag_pipe #(
        .MULT_LAT (MULT_LAT)
    ) u_tag_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .tag_i  (tag_in),
        .tag_o  (tag_out),
        .busy_o (busy)
    );

    // The tail tag lines up with the product now on mult_y.
    always_comb begin
        rsp_valid = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (tag_out.valid && tag_out.id == ID_W'(j)) begin
                rsp_valid[j] = 1'b1;
            end
        end
    end

    assign req_if.rsp_valid = rsp_valid;
    assign req_if.rsp_y     = mult_y;
    assign issue_cnt        = issue_cnt_q;
endmodule

// File: tb/tb_mult_share_arb.sv
module tb_mult_share_arb;
    import mult_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 2;

    typedef struct {
        int     id;
        int     a;
        int     b;
        longint due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  mult_a, mult_b;
    logic [15:0] mult_y;
    logic        busy;
    logic [31:0] issue_cnt;
    logic [7:0]  ref_a = '0, ref_b = '0;
    logic [15:0] ref_y;
    logic [15:0] last_y = '0;

    int     n_chk = 0;
    int     n_fail = 0;
    longint cyc = 0;
    int     m_ptr = 0;
    int     m_cnt = 0;
    exp_t   exp_q[$];
    int     glog[$];
    int     rlog[$];
    logic [15:0] opq [N][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_share_arb_if #(.NUM_REQ(N)) bus ();

    mult_share_arb #(.NUM_REQ(N), .MULT_LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_if    (bus),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_y    (mult_y),
        .busy      (busy),
        .issue_cnt (issue_cnt)
    );

    mult_wrapper u_mult (.clk(clk), .inA(mult_a), .inB(mult_b), .Y(mult_y));
    mult_wrapper u_ref  (.clk(clk), .inA(ref_a),  .inB(ref_b),  .Y(ref_y));

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Requesters must hold operands and valid while stalled.
    for (genvar i = 0; i < N; i++) begin : g_stab
        assert property (@(posedge clk) disable iff (!rst_n)
            (bus.req_valid[i] && !bus.req_ready[i]) |=>
            (bus.req_valid[i] && $stable(bus.req_a[i*8 +: 8]) && $stable(bus.req_b[i*8 +: 8])))
        else begin
            n_fail++;
            $display("FAIL operand_stable[%0d]: operands or valid changed while stalled, required held", i);
        end
    end

    // Requester driver: each requester presents the head of its op queue
    // and drops it once the handshake has been taken at an edge.
    initial begin : drv
        logic [N-1:0] hs;
        logic         rst_e;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        forever begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            @(posedge clk);
            rst_e = rst_n;
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && rst_e && opq[i].size() != 0) void'(opq[i].pop_front());
                bus.req_valid[i] = (opq[i].size() != 0);
                if (opq[i].size() != 0) begin
                    bus.req_a[i*8 +: 8] = opq[i][0][15:8];
                    bus.req_b[i*8 +: 8] = opq[i][0][7:0];
                end
            end
        end
    end

    // Reference model: round-robin rule evaluated on the offered valids.
    always @(negedge clk) begin : model
        int g;
        int p;
        logic [N-1:0] er;
        logic [7:0]   ea, eb;
        exp_t e;
        g  = -1;
        er = '0;
        ea = '0;
        eb = '0;
        for (int k = 0; k < N; k++) begin
            p = (m_ptr + k) % N;
            if (g < 0 && bus.req_valid[p]) g = p;
        end
        if (g >= 0) begin
            er[g] = 1'b1;
            ea = bus.req_a[g*8 +: 8];
            eb = bus.req_b[g*8 +: 8];
        end
        check("req_ready", bus.req_ready, er);
        check("mult_a", mult_a, ea);
        check("mult_b", mult_b, eb);
        ref_a = ea;
        ref_b = eb;
        if (g >= 0 && rst_n) begin
            e.id = g; e.a = ea; e.b = eb; e.due = cyc + LAT;
            exp_q.push_back(e);
            glog.push_back(g);
            m_cnt = m_cnt + 1;
            m_ptr = (g + 1) % N;
        end
    end

    always @(negedge rst_n) begin
        exp_q.delete();
        m_ptr = 0;
        m_cnt = 0;
    end

    // Monitor: pops the scoreboard whenever a response pulse appears.
    always @(posedge clk) begin : monitor
        exp_t e;
        int   diff;
        #2;
        check("busy", busy, exp_q.size() != 0);
        check("issue_cnt", issue_cnt, m_cnt);
        if (bus.rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", bus.rsp_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_due", cyc, e.due);
                check("rsp_valid", bus.rsp_valid, 64'(1) << e.id);
                check("rsp_y", bus.rsp_y, ref_y);
                diff = int'(bus.rsp_y) - e.a * e.b;
                check("approx_bound", (diff >= -7 && diff <= 7), 1);
                rlog.push_back(e.id);
                last_y = bus.rsp_y;
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            check("rsp_missing", bus.rsp_valid, 64'(1) << exp_q[0].id);
            void'(exp_q.pop_front());
        end
    end

    function automatic bit all_idle();
        for (int i = 0; i < N; i++) if (opq[i].size() != 0) return 1'b0;
        return exp_q.size() == 0;
    endfunction

    task automatic wait_idle(input int limit);
        int t;
        t = 0;
        while (t < limit && !all_idle()) begin
            @(negedge clk); #1;
            t++;
        end
        check("idle_timeout", t < limit, 1);
        repeat (2) begin @(negedge clk); #1; end
    endtask

    task automatic check_log(input string name, input int got[$], input int want[$]);
        check({name, "_len"}, got.size(), want.size());
        for (int k = 0; k < want.size() && k < got.size(); k++) check(name, got[k], want[k]);
    endtask

    task automatic clear_logs();
        glog.delete();
        rlog.delete();
    endtask

    task automatic push_op(input int i, input logic [7:0] a, input logic [7:0] b);
        opq[i].push_back({a, b});
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not reach the end, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int exp_l[$];
        int diff;
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_issue_cnt", issue_cnt, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_req_ready", bus.req_ready, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;

        // All four requesters valid, pointer at 0.
        clear_logs();
        for (int i = 0; i < N; i++) begin
            push_op(i, 8'($urandom), 8'($urandom));
            push_op(i, 8'($urandom), 8'($urandom));
        end
        wait_idle(100);
        exp_l = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_log("rr_all_grants", glog, exp_l);
        check_log("rr_all_rsps", rlog, exp_l);
        check("rr_all_cnt", issue_cnt, 8);

        // Single request from requester 2: 15 * 3.
        clear_logs();
        push_op(2, 8'd15, 8'd3);
        wait_idle(100);
        exp_l = '{2};
        check_log("single_grant", glog, exp_l);
        check_log("single_rsp", rlog, exp_l);
        diff = int'(last_y) - 45;
        check("single_y_bound", (diff >= -7 && diff <= 7), 1);
        check("single_cnt", issue_cnt, 9);

        // Move pointer to 2, then requesters 1 and 3 contend.
        push_op(1, 8'($urandom), 8'($urandom));
        wait_idle(100);
        clear_logs();
        push_op(1, 8'($urandom), 8'($urandom));
        push_op(3, 8'($urandom), 8'($urandom));
        wait_idle(100);
        exp_l = '{3, 1};
        check_log("skip_grants", glog, exp_l);
        clear_logs();
        for (int i = 0; i < N; i++) push_op(i, 8'($urandom), 8'($urandom));
        wait_idle(100);
        exp_l = '{2, 3, 0, 1};
        check_log("ptr_after_skip", glog, exp_l);
        check("skip_cnt", issue_cnt, 16);

        // Randomized traffic.
        for (int c = 0; c < 300; c++) begin
            @(negedge clk); #1;
            for (int i = 0; i < N; i++)
                if ($urandom_range(2) == 0 && opq[i].size() < 3) push_op(i, 8'($urandom), 8'($urandom));
        end
        wait_idle(500);

        // Reset right after two back-to-back issues.
        push_op(0, 8'($urandom), 8'($urandom));
        push_op(1, 8'($urandom), 8'($urandom));
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_cnt", issue_cnt, 0);
        check("midrst_rsp", bus.rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) begin @(negedge clk); #1; end
        clear_logs();
        push_op(3, 8'($urandom), 8'($urandom));
        push_op(1, 8'($urandom), 8'($urandom));
        wait_idle(100);
        exp_l = '{1, 3};
        check_log("post_rst_grants", glog, exp_l);

        // Requester 1 stalled behind requester 0 with held operands.
        clear_logs();
        push_op(0, 8'd200, 8'd17);
        push_op(1, 8'd99, 8'd123);
        wait_idle(100);
        exp_l = '{0, 1};
        check_log("stall_rsps", rlog, exp_l);

        // Exhaustive sweep on requester 0 from a fresh reset.
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        clear_logs();
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 256; b++) push_op(0, 8'(a), 8'(b));
        wait_idle(70000);
        check("sweep_cnt", issue_cnt, 65536);
        check("sweep_rsps", rlog.size(), 65536);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
